// File: rtl/rat_intr_ctrl.sv
// Push-button interrupt source for the RAT CPU: synchronise, debounce, count
// presses and hold a level request until the CPU acknowledges it.
module rat_intr_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned MAX_PENDING     = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_IN,
  input  logic       INT_ACK,
  input  logic       OVF_CLR,
  output logic       INTR,
  output logic [3:0] PENDING,
  output logic       OVF,
  output logic       BTN_CLEAN
);

  localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      PEND_MAX = 4'(MAX_PENDING);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_clean;
  logic          r_clean_d;
  logic [3:0]    r_pend;
  logic          r_ovf;
  logic [1:0]    r_state;
  logic          r_intr;

  logic          w_press;
  logic          w_ack;
  logic [3:0]    w_pend_nxt;
  logic          w_ovf_set;
  logic [1:0]    w_state_nxt;

  assign w_press = r_clean & ~r_clean_d;
  assign w_ack   = INT_ACK & (r_state == S_REQ);

  always_comb begin
    w_pend_nxt = r_pend;
    w_ovf_set  = 1'b0;
    if (w_press && !w_ack) begin
      if (r_pend < PEND_MAX) w_pend_nxt = r_pend + 4'd1;
      else                   w_ovf_set  = 1'b1;
    end else if (w_ack && !w_press && r_pend != '0) begin
      w_pend_nxt = r_pend - 4'd1;
    end
  end

  // GAP exit looks at the post-update count so a press during GAP is honoured
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_press) w_state_nxt = S_REQ;
      S_REQ:   if (INT_ACK) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = (w_pend_nxt != '0) ? S_REQ : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_clean   <= 1'b0;
      r_clean_d <= 1'b0;
      r_pend    <= '0;
      r_ovf     <= 1'b0;
      r_state   <= S_IDLE;
      r_intr    <= 1'b0;
    end else begin
      r_sync1   <= BTN_IN;
      r_sync2   <= r_sync1;
      r_clean_d <= r_clean;
      if (r_sync2 == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_clean <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_pend <= w_pend_nxt;
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (OVF_CLR) r_ovf <= 1'b0;
      r_state <= w_state_nxt;
      r_intr  <= (w_state_nxt == S_REQ);
    end
  end

  assign INTR      = r_intr;
  assign PENDING   = r_pend;
  assign OVF       = r_ovf;
  assign BTN_CLEAN = r_clean;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Bench for rat_intr_ctrl: fixed vector table, directed corner sequences and
// randomised button/ack traffic against a behavioural model.
module tb_rat_intr_ctrl;
  localparam int unsigned DB = 4;
  localparam int unsigned MP = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_IN = 1'b0;
  logic       INT_ACK = 1'b0;
  logic       OVF_CLR = 1'b0;
  logic       INTR;
  logic [3:0] PENDING;
  logic       OVF;
  logic       BTN_CLEAN;

  always #5 CLK = ~CLK;

  rat_intr_ctrl #(.DEBOUNCE_CYCLES(DB), .MAX_PENDING(MP)) dut (
    .CLK(CLK), .RST(RST), .BTN_IN(BTN_IN), .INT_ACK(INT_ACK), .OVF_CLR(OVF_CLR),
    .INTR(INTR), .PENDING(PENDING), .OVF(OVF), .BTN_CLEAN(BTN_CLEAN)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: two-stage delay, run length of disagreeing samples, press count,
  // and a one-cycle forced-low flag after each serviced request.
  bit m_s1, m_s2, m_clean, m_prev, m_ovf, m_gap;
  int m_run, m_pend;

  function automatic bit m_intr();
    return (m_pend > 0) && !m_gap;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit btn, input bit ack, input bit clr);
    bit press, acc, oset;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_clean = 0; m_prev = 0; m_ovf = 0; m_gap = 0;
      m_run = 0; m_pend = 0;
      return;
    end
    press  = m_clean && !m_prev;
    acc    = ack && m_intr();
    m_prev = m_clean;
    if (m_s2 == m_clean) m_run = 0;
    else begin
      m_run++;
      if (m_run == DB) begin m_clean = m_s2; m_run = 0; end
    end
    m_s2 = m_s1;
    m_s1 = btn;
    oset = 0;
    if (press && !acc) begin
      if (m_pend < MP) m_pend++;
      else oset = 1;
    end else if (acc && !press && m_pend > 0) begin
      m_pend--;
    end
    if (oset) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_gap = acc;
  endtask

  task automatic cyc(input bit rst, input bit btn, input bit ack, input bit clr);
    RST = rst; BTN_IN = btn; INT_ACK = ack; OVF_CLR = clr;
    @(posedge CLK);
    model_edge(rst, btn, ack, clr);
    #1;
    chk("intr",    INTR,      m_intr());
    chk("pending", PENDING,   m_pend);
    chk("ovf",     OVF,       m_ovf);
    chk("clean",   BTN_CLEAN, m_clean);
  endtask

  task automatic press_release();
    repeat (7) cyc(0, 1, 0, 0);
    repeat (7) cyc(0, 0, 0, 0);
  endtask

  typedef struct {
    bit rst, btn, ack, clr;
    bit intr;
    int pend;
    bit ovf, clean;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int k;
    bit found;
    bit lvl;
    int len;

    // rst btn ack clr | intr pend ovf clean
    tbl.push_back('{1,0,0,0, 0,0,0,0});
    tbl.push_back('{1,0,0,0, 0,0,0,0});
    tbl.push_back('{0,1,0,0, 0,0,0,0});  // edge 1
    tbl.push_back('{0,1,0,0, 0,0,0,0});
    tbl.push_back('{0,1,0,0, 0,0,0,0});
    tbl.push_back('{0,1,0,0, 0,0,0,0});
    tbl.push_back('{0,1,0,0, 0,0,0,0});  // edge 5
    tbl.push_back('{0,1,0,0, 0,0,0,1});  // edge 6: clean
    tbl.push_back('{0,1,0,0, 1,1,0,1});  // edge 7: request
    tbl.push_back('{0,1,0,0, 1,1,0,1});
    tbl.push_back('{0,1,1,0, 0,0,0,1});  // ack accepted
    tbl.push_back('{0,1,0,0, 0,0,0,1});  // back to idle
    tbl.push_back('{0,1,1,0, 0,0,0,1});  // ack in idle ignored
    tbl.push_back('{0,0,0,0, 0,0,0,1});  // release
    tbl.push_back('{0,0,0,0, 0,0,0,1});
    tbl.push_back('{0,0,0,0, 0,0,0,1});
    tbl.push_back('{0,0,0,0, 0,0,0,1});
    tbl.push_back('{0,0,0,0, 0,0,0,1});
    tbl.push_back('{0,0,0,0, 0,0,0,0});  // clean drops, no press
    tbl.push_back('{0,1,0,0, 0,0,0,0});  // 3-cycle glitch
    tbl.push_back('{0,1,0,0, 0,0,0,0});
    tbl.push_back('{0,1,0,0, 0,0,0,0});
    tbl.push_back('{0,0,0,0, 0,0,0,0});
    tbl.push_back('{0,0,0,0, 0,0,0,0});
    tbl.push_back('{0,0,0,0, 0,0,0,0});
    tbl.push_back('{0,0,0,0, 0,0,0,0});
    tbl.push_back('{0,0,0,0, 0,0,0,0});

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].btn, tbl[i].ack, tbl[i].clr);
      chk("tbl_intr",    INTR,      tbl[i].intr);
      chk("tbl_pending", PENDING,   tbl[i].pend);
      chk("tbl_ovf",     OVF,       tbl[i].ovf);
      chk("tbl_clean",   BTN_CLEAN, tbl[i].clean);
    end

    // bounce 1,0,1,1,1,1 then held: exactly one press
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (12) cyc(0, 1, 0, 0);
    chk("bounce_pending", PENDING, 1);
    repeat (7) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("bounce_idle", PENDING, 0);

    // overflow and clear
    press_release();
    press_release();
    press_release();
    chk("three_pending", PENDING, 3);
    chk("three_ovf", OVF, 0);
    press_release();
    chk("four_pending", PENDING, 3);
    chk("four_ovf", OVF, 1);
    cyc(0, 0, 0, 1);
    chk("clr_ovf", OVF, 0);
    chk("clr_pending", PENDING, 3);

    // ack sequencing from PENDING=2
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("req2_intr", INTR, 1);
    chk("req2_pending", PENDING, 2);
    cyc(0, 0, 1, 0);
    chk("gap_intr", INTR, 0);
    chk("gap_pending", PENDING, 1);
    cyc(0, 0, 0, 0);
    chk("rereq_intr", INTR, 1);
    cyc(0, 0, 1, 0);
    chk("last_ack_intr", INTR, 0);
    chk("last_ack_pending", PENDING, 0);
    cyc(0, 0, 0, 0);
    chk("idle_intr", INTR, 0);

    // press coinciding with ack at PENDING=1
    press_release();
    repeat (6) cyc(0, 1, 0, 0);
    chk("coinc_clean", BTN_CLEAN, 1);
    chk("coinc_pre_pending", PENDING, 1);
    cyc(0, 1, 1, 0);
    chk("coinc_pending", PENDING, 1);
    chk("coinc_gap", INTR, 0);
    cyc(0, 1, 0, 0);
    chk("coinc_req", INTR, 1);

    // reset mid-request with button held through it
    repeat (7) cyc(0, 0, 0, 0);
    repeat (7) cyc(0, 1, 0, 0);
    chk("pre_rst_pending", PENDING, 2);
    chk("pre_rst_intr", INTR, 1);
    cyc(1, 1, 0, 0);
    chk("rst_intr", INTR, 0);
    chk("rst_pending", PENDING, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_clean", BTN_CLEAN, 0);
    k = 0;
    found = 0;
    for (int e = 1; e <= 20 && !found; e++) begin
      cyc(0, 1, 0, 0);
      if (INTR === 1'b1) begin k = e; found = 1; end
    end
    chk("rst_relatch_edge", k, 7);
    chk("rst_relatch_pending", PENDING, 1);

    // randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      repeat (len)
        cyc($urandom_range(0, 299) == 0, lvl,
            $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
